// File: rtl/local_inject_queue.sv
// Flit/PV FIFO between the local core and the router inject stage; head is popped only on injectGrant.
// Optional head-starvation counter enabled by defining STARVE_CNT_EN.
module local_inject_queue #(
    parameter int FLIT_W    = 32,
    parameter int PV_W      = 5,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 4,
    parameter int STARVE_TH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     coreValid,
    input  logic [FLIT_W-1:0]        coreFlit,
    input  logic [PV_W-1:0]          corePV,
    output logic                     coreReady,
    output logic [FLIT_W-1:0]        dinLocal,
    output logic [PV_W-1:0]          PVLocal,
    output logic                     localValid,
    input  logic                     injectGrant,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     starve
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [FLIT_W-1:0] flit_mem [DEPTH];
    logic [PV_W-1:0]   pv_mem   [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [AW:0]       count;
    logic              empty, full, push, pop;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign push  = coreValid & ~full;
    assign pop   = injectGrant & ~empty;

    assign coreReady  = ~full;
    assign localValid = ~empty;
    assign occupancy  = count;
    assign dinLocal   = empty ? '0 : flit_mem[rd_ptr];
    assign PVLocal    = empty ? '0 : pv_mem[rd_ptr];

    // DEPTH is a power of two, so pointer wrap is plain modular increment
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; a write in a reset cycle is dropped
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            flit_mem[wr_ptr] <= coreFlit;
            pv_mem[wr_ptr]   <= corePV;
        end
    end

`ifdef STARVE_CNT_EN
    logic [CNT_W-1:0] wait_cnt, wait_nxt;

    // Counts edges where the head is present but not granted
    always_comb begin
        wait_nxt = wait_cnt;
        if (pop || empty)
            wait_nxt = '0;
        else if (wait_cnt != '1)
            wait_nxt = wait_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            starve   <= 1'b0;
        end else begin
            wait_cnt <= wait_nxt;
            starve   <= (int'(wait_nxt) >= STARVE_TH);
        end
    end
`else
    assign starve = 1'b0;
`endif

endmodule
